br_predict_unit: RTL

- Parametrised successor of the combinational branch/next-PC unit.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It predicts next PC at fetch, resolves branches at execute, and raises mispredict with a redirect PC.
- Sits between the fetch stage (prediction) and the execution unit (resolution, table update).

---
 rtl/br_predict_unit_pkg.sv | 22 ++
 rtl/br_predict_unit_sat_counter.sv | 20 ++
 rtl/br_predict_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/br_predict_unit_pkg.sv
// Shared constants for the branch predict unit: branch-op encodings,
// default BTB geometry and the 2-bit counter values used at reset/allocate.
package br_predict_unit_pkg;

  localparam int BR_OP_WIDTH_DFLT = 2;
  localparam int BTB_DEPTH_DFLT   = 16;
  localparam int TAG_WIDTH_DFLT   = 8;

  localparam int BR_EQ = 0;
  localparam int BR_NE = 1;
  localparam int BR_LT = 2;
  localparam int BR_GE = 3;

  typedef logic [1:0] ctr_t;

  // Weakly not-taken after reset; conditional branches allocate weakly
  // taken, unconditional jumps allocate strongly taken.
  localparam ctr_t CTR_RESET        = 2'b01;
  localparam ctr_t CTR_ALLOC_COND   = 2'b10;
  localparam ctr_t CTR_ALLOC_UNCOND = 2'b11;

endpackage

// File: rtl/br_predict_unit_sat_counter.sv
// 2-bit saturating up/down counter next-state function.
module br_sat_counter
  import br_predict_unit_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic inc_i,
  output ctr_t ctr_o
);

  // Step toward 3 on increment, toward 0 otherwise, holding at the ends.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && (ctr_i != 2'b11)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!inc_i && (ctr_i != 2'b00)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/br_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit counters, combinational
// fetch-time prediction, execute-time resolution and registered table update.
// Optional performance counters are enabled with the macro BR_PERF_CNT_EN.
module br_predict_unit
  import br_predict_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BR_OP_WIDTH = BR_OP_WIDTH_DFLT,
  parameter int BTB_DEPTH   = BTB_DEPTH_DFLT,
  parameter int IDX_BITS    = $clog2(BTB_DEPTH),
  parameter int TAG_WIDTH   = TAG_WIDTH_DFLT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  fetch_pc_i,
  output logic                   pred_taken_o,
  output logic [DATA_WIDTH-1:0]  pred_target_o,
  input  logic                   ex_valid_i,
  input  logic [DATA_WIDTH-1:0]  ex_pc_i,
  input  logic                   ex_is_branch_i,
  input  logic                   ex_is_conditional_i,
  input  logic [BR_OP_WIDTH-1:0] ex_br_op_i,
  input  logic                   ex_alu_zero_i,
  input  logic [DATA_WIDTH-1:0]  ex_alu_d_i,
  input  logic [DATA_WIDTH-1:0]  ex_imm_i,
  input  logic                   ex_pred_taken_i,
  input  logic [DATA_WIDTH-1:0]  ex_pred_target_i,
  output logic                   mispredict_o,
  output logic [DATA_WIDTH-1:0]  redirect_pc_o,
  output logic [DATA_WIDTH-1:0]  link_pc_o,
  output logic [31:0]            br_count_o,
  output logic [31:0]            mispred_count_o
);

  localparam logic [BR_OP_WIDTH-1:0] OP_EQ = BR_OP_WIDTH'(BR_EQ);
  localparam logic [BR_OP_WIDTH-1:0] OP_NE = BR_OP_WIDTH'(BR_NE);
  localparam logic [BR_OP_WIDTH-1:0] OP_LT = BR_OP_WIDTH'(BR_LT);
  localparam logic [BR_OP_WIDTH-1:0] OP_GE = BR_OP_WIDTH'(BR_GE);

  logic                  valid_q  [BTB_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q    [BTB_DEPTH];
  logic [DATA_WIDTH-1:0] target_q [BTB_DEPTH];
  ctr_t                  ctr_q    [BTB_DEPTH];

  logic [IDX_BITS-1:0]   fetch_idx, ex_idx;
  logic [TAG_WIDTH-1:0]  fetch_tag, ex_tag;
  logic                  fetch_hit, ex_hit;
  logic                  cond_met, taken, mispredict_raw;
  logic [DATA_WIDTH-1:0] seq_pc, actual_next;
  ctr_t                  ctr_upd;

  assign fetch_idx = fetch_pc_i[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc_i[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];
  assign ex_idx    = ex_pc_i[IDX_BITS+1:2];
  assign ex_tag    = ex_pc_i[IDX_BITS+TAG_WIDTH+1:IDX_BITS+2];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign pred_taken_o  = fetch_hit && ctr_q[fetch_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[fetch_idx]
                                      : fetch_pc_i + DATA_WIDTH'(4);

  // Branch resolution and flush/redirect generation.
  always_comb begin
    cond_met = 1'b0;
    unique case (ex_br_op_i)
      OP_EQ, OP_GE: cond_met = ex_alu_zero_i;
      OP_NE, OP_LT: cond_met = !ex_alu_zero_i;
      default:      cond_met = 1'b0;
    endcase
    taken       = ex_is_branch_i && (!ex_is_conditional_i || cond_met);
    seq_pc      = ex_pc_i + DATA_WIDTH'(4);
    actual_next = seq_pc;
    if (taken) begin
      actual_next = ex_is_conditional_i ? (ex_pc_i + ex_imm_i) : ex_alu_d_i;
    end
    // A non-branch predicted taken falls out here as taken=0 vs pred=1,
    // redirecting to the sequential PC.
    mispredict_raw = (taken != ex_pred_taken_i) ||
                     (taken && (actual_next != ex_pred_target_i));
    mispredict_o   = ex_valid_i && mispredict_raw;
    redirect_pc_o  = mispredict_o ? actual_next : '0;
    link_pc_o      = (ex_valid_i && ex_is_branch_i && !ex_is_conditional_i)
                     ? seq_pc : '0;
  end

  br_sat_counter u_sat_counter (
    .ctr_i (ctr_q[ex_idx]),
    .inc_i (taken),
    .ctr_o (ctr_upd)
  );

  // Valid bits and counters: reset, train on hit, allocate on taken miss,
  // invalidate aliased non-branch entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (ex_valid_i) begin
      if (ex_is_branch_i) begin
        if (ex_hit) begin
          ctr_q[ex_idx] <= ctr_upd;
        end else if (taken) begin
          valid_q[ex_idx] <= 1'b1;
          ctr_q[ex_idx]   <= ex_is_conditional_i ? CTR_ALLOC_COND : CTR_ALLOC_UNCOND;
        end
      end else if (ex_hit && ex_pred_taken_i) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

  // Tag and target payload; only meaningful while the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ex_valid_i && ex_is_branch_i && taken) begin
      target_q[ex_idx] <= actual_next;
      if (!ex_hit) begin
        tag_q[ex_idx] <= ex_tag;
      end
    end
  end

`ifdef BR_PERF_CNT_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  // Resolved-branch and mispredict event counters, wrapping at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (ex_valid_i && ex_is_branch_i) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_o)                 mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mp_cnt_q;
`else
  assign br_count_o      = '0;
  assign mispred_count_o = '0;
`endif

endmodule
